// File: rtl/mvm_host_driver_if.sv
// mvm_host_driver_if: host-side job/result streams plus the MVM control and
// data lines for the MVM host driver. The master modport is the host/MVM
// side. The slave modport is the driver.
interface mvm_host_driver_if #(
  parameter int B = 8
);
  logic                  in_valid;
  logic signed [B-1:0]   in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic signed [2*B-1:0] out_data;
  logic                  out_ready;
  logic                  busy;
  logic                  err;
  logic                  mvm_loadMatrix;
  logic                  mvm_loadVector;
  logic                  mvm_start;
  logic signed [B-1:0]   mvm_data_in;
  logic                  mvm_done;
  logic signed [2*B-1:0] mvm_data_out;

  modport master (
    output in_valid, in_data, out_ready, mvm_done, mvm_data_out,
    input  in_ready, out_valid, out_data, busy, err,
           mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in
  );

  modport slave (
    input  in_valid, in_data, out_ready, mvm_done, mvm_data_out,
    output in_ready, out_valid, out_data, busy, err,
           mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in
  );
endinterface

// File: rtl/mvm_host_driver.sv
// mvm_host_driver: accepts one K x K matrix-vector job over a stream, replays
// it to the MVM as contiguous bursts, captures the K results and streams them
// back. Every output is registered from the next-state decode, so a pulse is
// visible during the cycle spent in its state. Assumes K >= 2.
module mvm_host_driver #(
  parameter int K       = 20,
  parameter int B       = 8,
  parameter int OUT_LAT = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  mvm_host_driver_if.slave bus
);

  localparam int KK   = K * K;
  localparam int JOB  = KK + K;
  localparam int CAP  = OUT_LAT - 1 + K;
  localparam int M1   = (JOB > TIMEOUT) ? JOB : TIMEOUT;
  localparam int MAXC = (M1 > CAP) ? M1 : CAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int CW1  = CW + 1;
  localparam int JW   = $clog2(JOB);
  localparam int RW   = $clog2(K);

  localparam logic [CW-1:0] JOB_LAST = CW'(JOB - 1);
  localparam logic [CW-1:0] KK_LAST  = CW'(KK - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(K - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAP - 1);
  localparam logic [CW-1:0] SKIP     = CW'(OUT_LAT - 1);
  localparam logic [CW:0]   LAT_C    = CW1'(OUT_LAT);

  typedef enum logic [3:0] {
    S_FILL, S_LDM, S_SENDM, S_LDV, S_SENDV,
    S_GAP, S_STRT, S_WAIT, S_CAPT, S_DRAIN
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n, cap_idx;
  logic [CW:0]           cnt_inc;
  logic                  err_r, err_n;
  logic                  store_job, store_res;
  logic                  in_ready_r, out_valid_r, busy_r;
  logic                  ldm_r, ldv_r, start_r;
  logic signed [B-1:0]   data_in_r;
  logic signed [2*B-1:0] out_data_r;
  logic signed [B-1:0]   jbuf [JOB];
  logic signed [2*B-1:0] res  [K];
  logic                  accept, take;

  assign accept = bus.in_valid && in_ready_r;
  assign take   = out_valid_r && bus.out_ready;

  assign bus.in_ready       = in_ready_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_data       = out_data_r;
  assign bus.busy           = busy_r;
  assign bus.err            = err_r;
  assign bus.mvm_loadMatrix = ldm_r;
  assign bus.mvm_loadVector = ldv_r;
  assign bus.mvm_start      = start_r;
  assign bus.mvm_data_in    = data_in_r;

  // Next-state, counter and buffer-write decode; cnt restarts at 0 on every state exit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    err_n     = err_r;
    store_job = 1'b0;
    store_res = 1'b0;
    cnt_inc   = {1'b0, cnt} + CW1'(1);
    cap_idx   = cnt - SKIP;
    case (state)
      S_FILL: begin
        if (accept) begin
          store_job = 1'b1;
          if (cnt == JOB_LAST) begin
            state_n = S_LDM;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_LDM: state_n = S_SENDM;
      S_SENDM: begin
        if (cnt == KK_LAST) begin
          state_n = S_LDV;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_LDV: state_n = S_SENDV;
      S_SENDV: begin
        if (cnt == K_LAST) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_GAP:  state_n = S_STRT;
      S_STRT: state_n = S_WAIT;
      S_WAIT: begin
        if (bus.mvm_done) begin
          state_n = S_CAPT;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = S_FILL;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_CAPT: begin
        // The first OUT_LAT-1 cycles after done carry no result yet.
        store_res = (cnt_inc >= LAT_C);
        if (cnt == CAP_LAST) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (take) begin
          if (cnt == K_LAST) begin
            state_n = S_FILL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = S_FILL;
        cnt_n   = '0;
      end
    endcase
  end

  // Control state and registered outputs; reset drops every pulse on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FILL;
      cnt         <= '0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      ldm_r       <= 1'b0;
      ldv_r       <= 1'b0;
      start_r     <= 1'b0;
      data_in_r   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      err_r       <= err_n;
      in_ready_r  <= (state_n == S_FILL);
      out_valid_r <= (state_n == S_DRAIN);
      busy_r      <= !((state_n == S_FILL) && (cnt_n == '0));
      ldm_r       <= (state_n == S_LDM);
      ldv_r       <= (state_n == S_LDV);
      start_r     <= (state_n == S_STRT);
      if (state_n == S_SENDM) begin
        data_in_r <= jbuf[cnt_n[JW-1:0]];
      end else if (state_n == S_SENDV) begin
        data_in_r <= jbuf[JW'(KK) + cnt_n[JW-1:0]];
      end
    end
  end

  // Job/result storage and the result output word; contents need no reset.
  always_ff @(posedge clk) begin
    if (store_job) begin
      jbuf[cnt[JW-1:0]] <= bus.in_data;
    end
    if (store_res) begin
      res[cap_idx[RW-1:0]] <= bus.mvm_data_out;
    end
    if (state_n == S_DRAIN) begin
      out_data_r <= res[cnt_n[RW-1:0]];
    end
  end

endmodule
